coin_input_encoder: RTL

Upstream conditioning stage for the vending FSM. Synchronizes and debounces four raw coin/cancel sensor lines and detects their rising edges. Queues one pending event per line and condenses coin events into the 2-bit code consumed by the next-state logic, plus a separate cancel strobe. All outputs are registered, so the FSM's state register samples clean one-cycle events.

---
 rtl/coin_input_encoder.sv | 106 ++++++++++
 1 files changed

// File: rtl/coin_input_encoder.sv
// Coin/cancel sensor conditioning: 2-flop sync, per-line debounce, rise detect, one pending event per line,
// priority coin encoding plus cancel strobe. Optional audit counters when COIN_AUDIT_EN is defined.
module coin_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] coin_raw,
  input  logic       accept_en,
  output logic [1:0] eo,
  output logic       eo_valid,
  output logic       cancel_pulse,
  output logic [3:0] coin_overrun,
  input  logic [1:0] audit_sel,
  output logic [7:0] audit_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    s1, s2, stable, stable_q, pending, rise, clr;
  logic [CW-1:0] cnt [4];
  logic [1:0]    code;
  logic          coin_fire;

  assign rise = stable & ~stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1       <= coin_raw;
      s2       <= s1;
      stable_q <= stable;
      // A line must disagree with its stable level for DEBOUNCE_CYCLES consecutive cycles to flip it.
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Highest pending coin wins when the FSM accepts; cancel is independent of accept_en.
  always_comb begin
    clr       = '0;
    code      = 2'b00;
    coin_fire = 1'b0;
    if (accept_en) begin
      if (pending[2]) begin
        clr[2] = 1'b1; code = 2'b11; coin_fire = 1'b1;
      end else if (pending[1]) begin
        clr[1] = 1'b1; code = 2'b10; coin_fire = 1'b1;
      end else if (pending[0]) begin
        clr[0] = 1'b1; code = 2'b01; coin_fire = 1'b1;
      end
    end
    if (pending[3]) clr[3] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      coin_overrun <= '0;
      eo           <= 2'b00;
      eo_valid     <= 1'b0;
      cancel_pulse <= 1'b0;
    end else begin
      pending      <= (pending & ~clr) | rise;
      coin_overrun <= coin_overrun | (rise & pending & ~clr);
      eo           <= code;
      eo_valid     <= coin_fire;
      cancel_pulse <= pending[3];
    end
  end

`ifdef COIN_AUDIT_EN
  logic [7:0] audit_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) audit_cnt[i] <= '0;
      audit_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clr[i] && audit_cnt[i] != 8'hFF) audit_cnt[i] <= audit_cnt[i] + 8'd1;
      end
      audit_count <= audit_cnt[audit_sel];
    end
  end
`else
  logic unused_audit;
  assign unused_audit = ^audit_sel;
  assign audit_count  = 8'd0;
`endif

endmodule
